// File: rtl/crot_angle_sequencer_if.sv
// crot_angle_sequencer_if: start/amplitude/CROT-gate/tag signal bundle between a producer and the sequencer
interface crot_angle_sequencer_if #(
  parameter int N_QUBITS = 3,
  parameter int TOTAL_WIDTH = 8
);
  logic start;
  logic [2:0] tgt_q;
  logic [2:0] ctl_q;
  logic in_valid;
  logic in_ready;
  logic [TOTAL_WIDTH-1:0] in_r;
  logic [TOTAL_WIDTH-1:0] in_i;
  logic rot_valid;
  logic [TOTAL_WIDTH-1:0] rot_r;
  logic [TOTAL_WIDTH-1:0] rot_i;
  logic [TOTAL_WIDTH-1:0] rot_theta;
  logic tag_valid;
  logic [N_QUBITS-1:0] tag_idx;
  logic busy;
  logic done;
  logic cfg_err;
  modport master (
    output start, tgt_q, ctl_q, in_valid, in_r, in_i,
    input in_ready, rot_valid, rot_r, rot_i, rot_theta, tag_valid, tag_idx, busy, done, cfg_err
  );
  modport slave (
    input start, tgt_q, ctl_q, in_valid, in_r, in_i,
    output in_ready, rot_valid, rot_r, rot_i, rot_theta, tag_valid, tag_idx, busy, done, cfg_err
  );
endinterface

// File: rtl/crot_angle_sequencer.sv
// crot_angle_sequencer: streams a state vector into a CROT gate with per-index angles and tags its outputs.
// Define CROT_SEQ_CFG_CHECK_EN to reject start with tgt_q >= ctl_q or ctl_q >= N_QUBITS (sticky cfg_err).
module crot_angle_sequencer #(
  parameter int N_QUBITS = 3,
  parameter int CROT_LATENCY = 6,
  parameter int TOTAL_WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  crot_angle_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [N_QUBITS-1:0] idx_q, idx_d, rot_idx_q, rot_idx_d;
  logic [N_QUBITS-1:0] tag_idx_q [CROT_LATENCY];
  logic [N_QUBITS-1:0] tag_idx_d [CROT_LATENCY];
  logic [CROT_LATENCY-1:0] tag_v_q, tag_v_d;
  logic [2:0] sel_tgt_q, sel_tgt_d, sel_ctl_q, sel_ctl_d;
  logic [TOTAL_WIDTH-1:0] lut_q, lut_d, rot_r_q, rot_r_d, rot_i_q, rot_i_d, rot_theta_q, rot_theta_d;
  logic rot_valid_q, rot_valid_d, cfg_err_q, cfg_err_d, arm_q;
  logic accept, cfg_bad, hit, upstream;
  logic [7:0] idx_ext;
  // Angle pi/2^d in S3.4; zero or negative distance (bit 3 set) yields 0
  function automatic logic [TOTAL_WIDTH-1:0] theta_lut(input logic [3:0] diff);
    case (diff)
      4'd1: theta_lut = TOTAL_WIDTH'(25);
      4'd2: theta_lut = TOTAL_WIDTH'(13);
      4'd3: theta_lut = TOTAL_WIDTH'(6);
      4'd4: theta_lut = TOTAL_WIDTH'(3);
      4'd5: theta_lut = TOTAL_WIDTH'(2);
      4'd6: theta_lut = TOTAL_WIDTH'(1);
      default: theta_lut = '0;
    endcase
  endfunction
`ifdef CROT_SEQ_CFG_CHECK_EN
  assign cfg_bad = (bus.tgt_q >= bus.ctl_q) || (bus.ctl_q >= 3'(N_QUBITS));
`else
  assign cfg_bad = 1'b0;
`endif
  assign accept = (state_q == RUN) && bus.in_valid;
  assign idx_ext = 8'(idx_q);
  assign hit = idx_ext[sel_tgt_q] & idx_ext[sel_ctl_q];
  // Anything still upstream of the last tag stage keeps DRAIN alive
  always_comb begin
    upstream = rot_valid_q;
    for (int i = 0; i < CROT_LATENCY - 1; i++) upstream = upstream | tag_v_q[i];
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    sel_tgt_d = sel_tgt_q;
    sel_ctl_d = sel_ctl_q;
    lut_d = lut_q;
    cfg_err_d = cfg_err_q;
    case (state_q)
      IDLE: if (bus.start && arm_q) begin
        cfg_err_d = cfg_err_q | cfg_bad;
        state_d = cfg_bad ? IDLE : LOAD;
        sel_tgt_d = cfg_bad ? sel_tgt_q : bus.tgt_q;
        sel_ctl_d = cfg_bad ? sel_ctl_q : bus.ctl_q;
        lut_d = cfg_bad ? lut_q : theta_lut({1'b0, bus.ctl_q} - {1'b0, bus.tgt_q});
      end
      LOAD: begin
        idx_d = '0;
        state_d = RUN;
      end
      RUN: if (accept) begin
        idx_d = idx_q + 1'b1;
        state_d = (&idx_q) ? DRAIN : RUN;
      end
      DRAIN: state_d = upstream ? DRAIN : DONE;
      default: state_d = IDLE;
    endcase
    rot_valid_d = accept;
    rot_idx_d = accept ? idx_q : '0;
    rot_r_d = accept ? bus.in_r : '0;
    rot_i_d = accept ? bus.in_i : '0;
    rot_theta_d = (accept && hit) ? lut_q : '0;
    tag_v_d[0] = rot_valid_q;
    tag_idx_d[0] = rot_idx_q;
    for (int i = 1; i < CROT_LATENCY; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      sel_tgt_q <= '0;
      sel_ctl_q <= '0;
      lut_q <= '0;
      cfg_err_q <= 1'b0;
      arm_q <= 1'b0;
      rot_valid_q <= 1'b0;
      rot_idx_q <= '0;
      rot_r_q <= '0;
      rot_i_q <= '0;
      rot_theta_q <= '0;
      tag_v_q <= '0;
      tag_idx_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      sel_tgt_q <= sel_tgt_d;
      sel_ctl_q <= sel_ctl_d;
      lut_q <= lut_d;
      cfg_err_q <= cfg_err_d;
      arm_q <= 1'b1;
      rot_valid_q <= rot_valid_d;
      rot_idx_q <= rot_idx_d;
      rot_r_q <= rot_r_d;
      rot_i_q <= rot_i_d;
      rot_theta_q <= rot_theta_d;
      tag_v_q <= tag_v_d;
      tag_idx_q <= tag_idx_d;
    end
  end
  assign bus.in_ready = state_q == RUN;
  assign bus.busy = (state_q == LOAD) || (state_q == RUN) || (state_q == DRAIN);
  assign bus.done = state_q == DONE;
  assign bus.cfg_err = cfg_err_q;
  assign bus.rot_valid = rot_valid_q;
  assign bus.rot_r = rot_r_q;
  assign bus.rot_i = rot_i_q;
  assign bus.rot_theta = rot_theta_q;
  assign bus.tag_valid = tag_v_q[CROT_LATENCY-1];
  assign bus.tag_idx = tag_idx_q[CROT_LATENCY-1];
endmodule
